// File: rtl/mvu_pkg.sv
// ---------------------------------------------------------------------------
// mvu_pkg
// Shared definitions for the MVU output stream path:
//   - ptr_width / cnt_width : sizing helpers for FIFO pointers and occupancy
//   - vec_width             : packed result-vector width for PE lanes
//   - AF_MARGIN_DFLT        : default almost-full margin, equal to the
//                             number of results already in flight inside the
//                             PE pipeline when the control unit sees a stall.
// ---------------------------------------------------------------------------
package mvu_pkg;

  localparam int unsigned AF_MARGIN_DFLT = 3;

  // Pointer width; a single-entry FIFO still needs a 1-bit pointer.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy must represent 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned vec_width(input int unsigned pe,
                                            input int unsigned tdsti);
    return pe * tdsti;
  endfunction

endpackage

// File: rtl/mvu_out_stream_if.sv
// ---------------------------------------------------------------------------
// mvu_out_stream_if
// AXI-stream style result channel leaving the MVU output stage.
//   m_tvalid : beat valid            (master -> slave)
//   m_tready : downstream ready      (slave  -> master)
//   m_tdata  : packed result vector  (master -> slave), PE0 in the LSBs
//   m_tlast  : last beat of a frame  (master -> slave)
// ---------------------------------------------------------------------------
interface mvu_out_stream_if #(
  parameter int unsigned W = 16
) ();

  logic         m_tvalid;
  logic         m_tready;
  logic [W-1:0] m_tdata;
  logic         m_tlast;

  modport master (output m_tvalid, output m_tdata, output m_tlast,
                  input  m_tready);

  modport slave  (input  m_tvalid, input  m_tdata, input  m_tlast,
                  output m_tready);

endinterface

// File: rtl/mvu_sync_fifo.sv
// ---------------------------------------------------------------------------
// mvu_sync_fifo
// Register-array FIFO with first-word-fall-through read: rd_data_o always
// shows the entry at the read pointer, so data written at one edge is
// visible (empty_o=0) in the following cycle.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   wr_en_i      : write request; honoured if not full or if reading
//   wr_data_i    : write data
//   rd_en_i      : read request; honoured if not empty
//   rd_data_o    : head-of-queue data (registers only)
//   count_o      : occupancy 0..DEPTH
//   full_o       : count_o == DEPTH
//   empty_o      : count_o == 0
// DEPTH need not be a power of two; pointers wrap by explicit compare.
// ---------------------------------------------------------------------------
module mvu_sync_fifo
  import mvu_pkg::*;
#(
  parameter  int unsigned W     = 16,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned PW    = ptr_width(DEPTH),
  localparam int unsigned CW    = cnt_width(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_en_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic          rd_en_i,
  output logic [W-1:0]  rd_data_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_ok, rd_ok;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);

  // A full FIFO still accepts a write when a read frees the head slot in
  // the same cycle.
  assign rd_ok = rd_en_i && !empty_o;
  assign wr_ok = wr_en_i && (!full_o || rd_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end
    if (rd_ok) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset: contents are meaningless while empty.
  always_ff @(posedge clock) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/mvu_out_stream.sv
// ---------------------------------------------------------------------------
// mvu_out_stream
// Output stage behind the PE accumulators. Each in_acc_v pulse captures one
// result vector into a small FIFO; vectors leave on an AXI-stream style
// master port with tlast every NF beats. The accumulators cannot be
// stalled, so almost_full warns the control unit early enough that results
// still in the PE pipeline (AF_MARGIN of them) fit; anything that arrives
// with no room anyway is dropped and flagged on the sticky overflow.
// Ports:
//   clock, reset  : clock and synchronous active-high reset
//   in_acc_v      : result-vector valid
//   in_acc        : PE*TDstI packed results, PE0 in the LSBs
//   almost_full   : stall request, count >= DEPTH-AF_MARGIN
//   overflow      : sticky, a valid vector was dropped
//   m_axis        : result stream (m_tvalid/m_tready/m_tdata/m_tlast)
// Optional build macro MVU_OUT_PERF_CNT_EN adds saturating 32-bit counters:
//   perf_beats        : completed reads
//   perf_stall_cycles : cycles with almost_full=1
//   perf_bp_cycles    : cycles with m_tvalid && !m_tready
// ---------------------------------------------------------------------------
module mvu_out_stream
  import mvu_pkg::*;
#(
  parameter int unsigned PE        = 4,
  parameter int unsigned TDstI     = 4,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AF_MARGIN = AF_MARGIN_DFLT,
  parameter int unsigned NF        = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_acc_v,
  input  logic [vec_width(PE,TDstI)-1:0] in_acc,
  output logic                          almost_full,
  output logic                          overflow,
  mvu_out_stream_if.master              m_axis
`ifdef MVU_OUT_PERF_CNT_EN
  ,
  output logic [31:0]                   perf_beats,
  output logic [31:0]                   perf_stall_cycles,
  output logic [31:0]                   perf_bp_cycles
`endif
);

  localparam int unsigned VEC_W = vec_width(PE, TDstI);
  localparam int unsigned CW    = cnt_width(DEPTH);
  localparam int unsigned BW    = (NF > 1) ? $clog2(NF) : 1;

  localparam logic [CW-1:0] AF_THRESH = CW'(DEPTH - AF_MARGIN);
  localparam logic [BW-1:0] LAST_BEAT = BW'(NF - 1);

  typedef logic [VEC_W-1:0] vec_t;

  vec_t          fifo_rd_data;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          rd_fire;
  logic          wr_accept;

  logic          overflow_q, overflow_d;
  logic [BW-1:0] beat_q, beat_d;

  assign m_axis.m_tvalid = !fifo_empty;
  assign m_axis.m_tdata  = fifo_rd_data;
  assign rd_fire         = m_axis.m_tvalid && m_axis.m_tready;

  // Same acceptance rule the FIFO applies internally; needed here to know
  // when a vector is lost.
  assign wr_accept = in_acc_v && (!fifo_full || rd_fire);

  mvu_sync_fifo #(
    .W     (VEC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .wr_en_i   (in_acc_v),
    .wr_data_i (in_acc),
    .rd_en_i   (rd_fire),
    .rd_data_o (fifo_rd_data),
    .count_o   (fifo_count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  always_comb begin
    overflow_d = overflow_q | (in_acc_v & ~wr_accept);
    beat_d     = beat_q;
    if (rd_fire) begin
      beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_q <= 1'b0;
      beat_q     <= '0;
    end else begin
      overflow_q <= overflow_d;
      beat_q     <= beat_d;
    end
  end

  assign overflow       = overflow_q;
  assign almost_full    = (fifo_count >= AF_THRESH);
  // Beat counter only moves on a completed read, so tlast holds while the
  // downstream stalls.
  assign m_axis.m_tlast = m_axis.m_tvalid && (beat_q == LAST_BEAT);

`ifdef MVU_OUT_PERF_CNT_EN
  logic [31:0] perf_beats_q, perf_stall_q, perf_bp_q;
  logic        bp_now;

  assign bp_now = m_axis.m_tvalid && !m_axis.m_tready;

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_beats_q <= '0;
      perf_stall_q <= '0;
      perf_bp_q    <= '0;
    end else begin
      if (rd_fire && (perf_beats_q != '1)) begin
        perf_beats_q <= perf_beats_q + 1'b1;
      end
      if (almost_full && (perf_stall_q != '1)) begin
        perf_stall_q <= perf_stall_q + 1'b1;
      end
      if (bp_now && (perf_bp_q != '1)) begin
        perf_bp_q <= perf_bp_q + 1'b1;
      end
    end
  end

  assign perf_beats        = perf_beats_q;
  assign perf_stall_cycles = perf_stall_q;
  assign perf_bp_cycles    = perf_bp_q;
`endif

endmodule

// File: tb/tb_mvu_out_stream.sv
// ---------------------------------------------------------------------------
// tb_mvu_out_stream
// Directed bench for mvu_out_stream (PE=4, TDstI=4, DEPTH=8, AF_MARGIN=3,
// NF=4). A table of per-cycle records covers fill, backpressure, full with
// simultaneous read/write, drop and drain; hand-written sequences cover the
// single-vector latency, framing under random tready and reset mid-stream.
// Build with MVU_OUT_PERF_CNT_EN to also connect and check the perf ports.
// ---------------------------------------------------------------------------
module tb_mvu_out_stream;

  localparam int unsigned PE    = 4;
  localparam int unsigned TDSTI = 4;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AFM   = 3;
  localparam int unsigned NF    = 4;
  localparam int unsigned W     = PE * TDSTI;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_acc_v;
  logic [W-1:0] in_acc;
  logic         almost_full;
  logic         overflow;

  mvu_out_stream_if #(.W(W)) axis ();

`ifdef MVU_OUT_PERF_CNT_EN
  logic [31:0] perf_beats;
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_bp_cycles;
`endif

  always #5 clock = ~clock;

  mvu_out_stream #(
    .PE        (PE),
    .TDstI     (TDSTI),
    .DEPTH     (DEPTH),
    .AF_MARGIN (AFM),
    .NF        (NF)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .in_acc_v    (in_acc_v),
    .in_acc      (in_acc),
    .almost_full (almost_full),
    .overflow    (overflow),
    .m_axis      (axis.master)
`ifdef MVU_OUT_PERF_CNT_EN
    ,
    .perf_beats        (perf_beats),
    .perf_stall_cycles (perf_stall_cycles),
    .perf_bp_cycles    (perf_bp_cycles)
`endif
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         rdy;
    logic         tv;
    logic [W-1:0] td;
    logic         tl;
    logic         af;
    logic         ovf;
  } row_t;

  row_t tbl[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    in_acc_v      = 1'b0;
    in_acc        = '0;
    axis.m_tready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  function automatic row_t mk(input logic v, input logic [W-1:0] d,
                              input logic rdy, input logic tv,
                              input logic [W-1:0] td, input logic tl,
                              input logic af, input logic ovf);
    row_t r;
    r.v = v; r.d = d; r.rdy = rdy; r.tv = tv;
    r.td = td; r.tl = tl; r.af = af; r.ovf = ovf;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int           exp_beats;
    int           exp_bp;
    int           exp_stall;
    logic         tv_pre;
    logic         af_pre;
    int           wr_n;
    int           rd_n;
    int           cyc;
    logic         read_now;
    logic         tv_exp;
    logic [W-1:0] exp_q[$];

    // ---------------- reset state ----------------
    do_reset();
    check("rst_tvalid", 32'(axis.m_tvalid), 32'd0);
    check("rst_tlast",  32'(axis.m_tlast),  32'd0);
    check("rst_af",     32'(almost_full),   32'd0);
    check("rst_ovf",    32'(overflow),      32'd0);

    // ---------------- single vector, 1-cycle latency ----------------
    in_acc_v = 1'b1; in_acc = 16'hA5C3; axis.m_tready = 1'b1;
    tick();
    in_acc_v = 1'b0;
    $display("single: tvalid=%0b tdata=%h", axis.m_tvalid, axis.m_tdata);
    check("single_tvalid", 32'(axis.m_tvalid), 32'd1);
    check("single_tdata",  32'(axis.m_tdata),  32'hA5C3);
    check("single_tlast",  32'(axis.m_tlast),  32'd0);
    check("single_af",     32'(almost_full),   32'd0);
    tick();
    check("single_drained", 32'(axis.m_tvalid), 32'd0);

    // ---------------- table: fill, full r/w, drop, drain ----------------
    // Expected values are the outputs just after the clock edge.
    for (int i = 1; i <= 8; i++) begin
      tbl.push_back(mk(1'b1, 16'(i), 1'b0, 1'b1, 16'h0001, 1'b0,
                       (i >= 5), 1'b0));
    end
    tbl.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b1, 1'b0)); // stalled, stable
    tbl.push_back(mk(1'b1, 16'h0009, 1'b1, 1'b1, 16'h0002, 1'b0, 1'b1, 1'b0)); // full + read + write
    tbl.push_back(mk(1'b1, 16'h00FF, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b1, 1'b1)); // dropped
    tbl.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0003, 1'b0, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0004, 1'b1, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0004, 1'b1, 1'b1, 1'b1)); // tlast held
    tbl.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0005, 1'b0, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0006, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0007, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0008, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0009, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1));

    do_reset();
    exp_beats = 0; exp_bp = 0; exp_stall = 0;
    tv_pre = 1'b0; af_pre = 1'b0;
    for (int i = 0; i < tbl.size(); i++) begin
      in_acc_v      = tbl[i].v;
      in_acc        = tbl[i].d;
      axis.m_tready = tbl[i].rdy;
      if (tv_pre && tbl[i].rdy)  exp_beats++;
      if (tv_pre && !tbl[i].rdy) exp_bp++;
      if (af_pre)                exp_stall++;
      tick();
      $display("row %0d: v=%0b d=%h rdy=%0b -> tvalid=%0b tdata=%h tlast=%0b af=%0b ovf=%0b",
               i, tbl[i].v, tbl[i].d, tbl[i].rdy, axis.m_tvalid, axis.m_tdata,
               axis.m_tlast, almost_full, overflow);
      check($sformatf("row%0d_tvalid", i), 32'(axis.m_tvalid), 32'(tbl[i].tv));
      if (tbl[i].tv) begin
        check($sformatf("row%0d_tdata", i), 32'(axis.m_tdata), 32'(tbl[i].td));
      end
      check($sformatf("row%0d_tlast", i), 32'(axis.m_tlast), 32'(tbl[i].tl));
      check($sformatf("row%0d_af", i),    32'(almost_full),  32'(tbl[i].af));
      check($sformatf("row%0d_ovf", i),   32'(overflow),     32'(tbl[i].ovf));
      tv_pre = tbl[i].tv;
      af_pre = tbl[i].af;
    end
    in_acc_v = 1'b0;
    axis.m_tready = 1'b0;

`ifdef MVU_OUT_PERF_CNT_EN
    $display("perf: beats=%0d stall=%0d bp=%0d", perf_beats, perf_stall_cycles, perf_bp_cycles);
    check("perf_beats", perf_beats,        32'(exp_beats));
    check("perf_stall", perf_stall_cycles, 32'(exp_stall));
    check("perf_bp",    perf_bp_cycles,    32'(exp_bp));
`endif

    // ---------------- framing under random tready ----------------
    do_reset();
    wr_n = 0; rd_n = 0; cyc = 0;
    exp_q.delete();
    while (rd_n < 10 && cyc < 300) begin
      axis.m_tready = 1'($urandom_range(0, 1));
      if (wr_n < 10 && (wr_n - rd_n) < int'(DEPTH)) begin
        in_acc_v = 1'b1;
        in_acc   = 16'h0100 + 16'(wr_n);
      end else begin
        in_acc_v = 1'b0;
      end
      tv_exp = (exp_q.size() != 0);
      check("frame_tvalid", 32'(axis.m_tvalid), 32'(tv_exp));
      check("frame_tlast",  32'(axis.m_tlast),  32'(tv_exp && (rd_n % 4 == 3)));
      read_now = axis.m_tvalid && axis.m_tready;
      if (read_now) begin
        $display("beat %0d: tdata=%h tlast=%0b", rd_n, axis.m_tdata, axis.m_tlast);
        if (exp_q.size() == 0) begin
          check("frame_extra_beat", 32'd1, 32'd0);
        end else begin
          check("frame_tdata", 32'(axis.m_tdata), 32'(exp_q[0]));
        end
      end
      tick();
      if (in_acc_v) begin
        exp_q.push_back(in_acc);
        wr_n++;
      end
      if (read_now) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        rd_n++;
      end
      cyc++;
    end
    in_acc_v = 1'b0;
    axis.m_tready = 1'b0;
    check("frame_beats_done", 32'(rd_n), 32'd10);
    check("frame_ovf", 32'(overflow), 32'd0);

    // ---------------- reset mid-operation ----------------
    do_reset();
    for (int i = 0; i < 9; i++) begin
      in_acc_v = 1'b1;
      in_acc   = 16'h0200 + 16'(i);
      tick();
    end
    in_acc_v = 1'b0;
    check("pre_rst_ovf", 32'(overflow),    32'd1);
    check("pre_rst_af",  32'(almost_full), 32'd1);
    axis.m_tready = 1'b1;
    tick();
    tick();                       // beat counter now mid-frame
    axis.m_tready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    $display("after reset: tvalid=%0b af=%0b ovf=%0b", axis.m_tvalid, almost_full, overflow);
    check("midrst_tvalid", 32'(axis.m_tvalid), 32'd0);
    check("midrst_af",     32'(almost_full),   32'd0);
    check("midrst_ovf",    32'(overflow),      32'd0);
    check("midrst_tlast",  32'(axis.m_tlast),  32'd0);
    for (int i = 0; i < 4; i++) begin
      in_acc_v = 1'b1;
      in_acc   = 16'h1234 + 16'(i);
      tick();
    end
    in_acc_v = 1'b0;
    for (int k = 0; k < 4; k++) begin
      $display("post-reset beat %0d: tdata=%h tlast=%0b", k, axis.m_tdata, axis.m_tlast);
      check("postrst_tvalid", 32'(axis.m_tvalid), 32'd1);
      check("postrst_tdata",  32'(axis.m_tdata),  32'h1234 + 32'(k));
      check("postrst_tlast",  32'(axis.m_tlast),  32'(k == 3));
      axis.m_tready = 1'b1;
      tick();
    end
    axis.m_tready = 1'b0;
    check("postrst_empty", 32'(axis.m_tvalid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mvu_out_stream.md
Name: mvu_out_stream

Overview:
- Output stage directly downstream of the PE accumulators in the MVU stream path.
- Captures one result vector (one accumulator value per PE) on each accumulator output-valid pulse into a small FIFO.
- Emits results on an AXI-stream style master interface with tvalid/tready backpressure and tlast framing.
- Drives almost_full back to the control unit, which stops do_mvu_stream, because the accumulators cannot be back-pressured.

Parameters:
- PE, 4, number of processing elements (lanes per output vector).
- TDstI, 4, accumulator/result width per PE in bits.
- DEPTH, 8, FIFO entries (vectors); any integer >= AF_MARGIN+2.
- AF_MARGIN, 3, free entries reserved for results already in the PE pipeline when stall asserts.
- NF, 16, output vectors per frame; m_tlast marks every NF-th beat.

Ports:
- clock, in, 1, single clock; all logic is rising-edge.
- reset, in, 1, synchronous active-high reset.
- in_acc_v, in, 1, result-vector valid (common out_acc_v of all PEs).
- in_acc, in, PE*TDstI, concatenated PE results; PE0 in bits [TDstI-1:0].
- almost_full, out, 1, stall request to control unit.
- overflow, out, 1, sticky: a valid vector was dropped.
- m_tvalid, out, 1, output beat valid.
- m_tready, in, 1, downstream ready.
- m_tdata, out, PE*TDstI, output vector, same packing as in_acc.
- m_tlast, out, 1, last beat of frame.

Behaviour:
- Reset (reset=1 at a clock edge): count, wr_ptr, rd_ptr and beat counter go to 0; overflow=0; m_tvalid=0; m_tlast=0; almost_full=0. m_tdata is don't-care while m_tvalid=0. Reset mid-transfer discards all stored vectors without emitting them.
- Storage: DEPTH x (PE*TDstI) register array.
  - wr_ptr and rd_ptr wrap from DEPTH-1 to 0 by explicit compare; no power-of-two requirement.
  - count ranges 0..DEPTH.
- Read handshake: a read occurs when m_tvalid && m_tready.
  - m_tvalid = (count != 0).
  - m_tdata = mem[rd_ptr]. It is driven from registers only, so there is no combinational path from in_acc.
  - m_tdata and m_tlast stay stable while m_tvalid && !m_tready.
- Write rule:
  - in_acc_v=1 writes in_acc at wr_ptr if count < DEPTH, or if count == DEPTH and a read occurs in the same cycle.
  - Otherwise the vector is dropped, overflow sets, and overflow remains set until reset.
- Latency: a vector written at edge t appears with m_tvalid=1 in the cycle after edge t, i.e. 1-cycle latency when empty.
- count update:
  - +1 on write only.
  - -1 on read only.
  - Unchanged on simultaneous write and read, including when empty (write at empty has no same-cycle read, since m_tvalid=0) and when full.
- almost_full = (count >= DEPTH - AF_MARGIN), decoded from the registered count.
- Framing:
  - The beat counter increments on each read and wraps NF-1 -> 0.
  - m_tlast = m_tvalid && (beat counter == NF-1).
  - NF=1 asserts m_tlast on every beat.
- No arithmetic is performed on data; vectors pass bit-exact.

Optional Feature:
- Macro: MVU_OUT_PERF_CNT_EN.
- With the macro defined, the block adds three ports:
  - perf_beats, 32-bit output: count of completed reads.
  - perf_stall_cycles, 32-bit output: cycles with almost_full=1.
  - perf_bp_cycles, 32-bit output: cycles with m_tvalid && !m_tready.
  - All three reset to 0 and saturate at 2^32-1.
- Without the macro, these ports and counters do not exist, and all other behaviour is identical.

Decomposition:
- Shared package mvu_pkg:
  - function clog2-based width helpers for pointer/count widths;
  - typedef for the packed result vector, logic [PE*TDstI-1:0] per instantiation via parameterized localparam;
  - localparam default AF_MARGIN = 3, matching the PE pipeline depth.
- One natural sub-module: mvu_sync_fifo, a parameterized register-array FIFO exposing count, full and empty.
- mvu_out_stream wraps mvu_sync_fifo and adds the almost_full decode, the overflow flag, tlast framing and the perf counters.

Test Plan:
- Single vector: in_acc_v pulse with in_acc=16'hA5C3, m_tready=1 -> m_tvalid=1 next cycle with m_tdata=16'hA5C3, then m_tvalid=0.
- Backpressure: 8 writes 0x0001..0x0008 with m_tready=0.
  - almost_full rises after the 5th write (count=5).
  - overflow stays 0.
  - Releasing m_tready drains 0x0001..0x0008 in order, m_tdata stable while stalled.
- Overflow: DEPTH=8 full with m_tready=0, 9th in_acc_v -> overflow=1 (sticky), stored data unchanged. Then full with m_tready=1 plus in_acc_v in the same cycle -> accepted, count stays 8, no overflow.
- Framing: NF=4, stream 10 beats with random m_tready -> m_tlast on beats 4 and 8 only, and on no other beat.
- Reset mid-operation: 3 vectors queued, reset=1 for one cycle -> m_tvalid=0, almost_full=0, overflow=0 next cycle. A new vector 0x1234 then emerges as beat 0 of a frame (m_tlast timing restarts).
- With MVU_OUT_PERF_CNT_EN: the backpressure scenario yields perf_beats=8, perf_bp_cycles = number of tvalid && !tready cycles, perf_stall_cycles = cycles with count >= 5.
